// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: mode-0 SPI slave shifter driven by pre-synchronised SCLK edge strobes
module spi_slave_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift, rx_shift_d, tx_shift, tx_shift_d, hold, hold_d, rx_data_d;
  logic hold_empty, hold_empty_d, reload_pend, reload_pend_d;
  logic miso_d, rx_valid_d, tx_underrun_d, frame_err_d;
  logic rise, fall, reload, xfer;
  assign tx_ready = hold_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_empty  <= 1'b1;
      reload_pend <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      miso        <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      rx_shift    <= rx_shift_d;
      tx_shift    <= tx_shift_d;
      hold        <= hold_d;
      hold_empty  <= hold_empty_d;
      reload_pend <= reload_pend_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      tx_underrun <= tx_underrun_d;
      frame_err   <= frame_err_d;
      miso        <= miso_d;
    end
  end
  always_comb begin
    rise          = sclk_rise && !sclk_fall;
    fall          = sclk_fall && !sclk_rise;
    xfer          = tx_valid && hold_empty;
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    rx_shift_d    = rx_shift;
    tx_shift_d    = tx_shift;
    rx_data_d     = rx_data;
    reload_pend_d = reload_pend;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    reload        = 1'b0;
    if (state == IDLE) begin
      if (!cs_n) begin
        state_d       = SHIFT;
        bit_cnt_d     = '0;
        reload_pend_d = 1'b0;
        reload        = 1'b1;
      end
    end else if (cs_n) begin
      state_d       = IDLE;
      frame_err_d   = bit_cnt != '0;
      reload_pend_d = 1'b0;
    end else begin
      if (rise) begin
        rx_shift_d    = {rx_shift[WIDTH-2:0], mosi};
        rx_valid_d    = bit_cnt == CW'(WIDTH-1);
        rx_data_d     = rx_valid_d ? rx_shift_d : rx_data;
        bit_cnt_d     = rx_valid_d ? '0 : bit_cnt + 1'b1;
        reload_pend_d = reload_pend || rx_valid_d;
      end
      if (fall) begin
        reload        = reload_pend;
        reload_pend_d = 1'b0;
        tx_shift_d    = {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
    tx_shift_d    = reload ? (hold_empty ? '0 : hold) : tx_shift_d;
    tx_underrun_d = reload && hold_empty;
    hold_d        = xfer ? tx_data : hold;
    hold_empty_d  = xfer ? 1'b0 : (reload ? 1'b1 : hold_empty);
    miso_d        = state_d == SHIFT && tx_shift_d[WIDTH-1];
  end
endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: scoreboard bench for the SPI slave shifter
module tb_spi_slave_shifter;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, sclk_rise = 1'b0, sclk_fall = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic miso, tx_ready, rx_valid, tx_underrun, frame_err;
  logic [W-1:0] rx_data;
  int n_chk = 0, n_err = 0, n_under = 0, n_ferr = 0, exp_under = 0, exp_ferr = 0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] hold = '0, cur = '0, last_rx = '0;
  logic full = 1'b0;
  always #5 clk = ~clk;
  spi_slave_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_err(frame_err)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick;
  endtask
  task automatic load(input logic [W-1:0] w);
    check("tx_ready_free", tx_ready, 1);
    tx_data = w;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    hold = w;
    full = 1'b1;
    check("tx_ready_full", tx_ready, 0);
  endtask
  task automatic consume;
    cur = full ? hold : '0;
    if (!full) exp_under++;
    full = 1'b0;
  endtask
  task automatic start;
    cs_n = 1'b0;
    tick;
    consume;
  endtask
  task automatic frame(input logic [W-1:0] w, input int nbits, input int half, input bit ld,
                       input logic [W-1:0] nw, input int both_at);
    logic [W-1:0] got;
    got = '0;
    if (nbits == W) rx_q.push_back(w);
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = W - 1 - k;
      mosi = w[i];
      if (k == both_at) begin
        sclk_rise = 1'b1;
        sclk_fall = 1'b1;
        tick;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
      end
      got[i] = miso;
      sclk_rise = 1'b1;
      tick;
      sclk_rise = 1'b0;
      idle(half - 1);
      if (ld && k == 3 && !full) load(nw);
      sclk_fall = 1'b1;
      tick;
      sclk_fall = 1'b0;
      idle(half - 1);
    end
    if (nbits == W) begin
      check("miso_frame", got, cur);
      last_rx = w;
      consume;
    end
  endtask
  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_expected", rx_q.size() > 0, 1);
      if (rx_q.size() > 0) check("rx_data", rx_data, rx_q.pop_front());
    end
    if (tx_underrun) n_under++;
    if (frame_err) n_ferr++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end
  initial begin
    idle(3);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    tick;
    load(8'hA5);
    start;
    frame(8'h3C, W, 2, 1'b0, '0, -1);
    cs_n = 1'b1;
    idle(3);
    check("single_under", n_under, exp_under);
    check("single_rx_q", rx_q.size(), 0);
    load(8'h81);
    start;
    frame(8'hC3, W, 3, 1'b1, 8'h7E, -1);
    frame(8'h5A, W, 2, 1'b0, '0, -1);
    cs_n = 1'b1;
    idle(3);
    check("b2b_rx_q", rx_q.size(), 0);
    start;
    frame(8'h96, W, 2, 1'b0, '0, -1);
    cs_n = 1'b1;
    idle(3);
    check("underrun_cnt", n_under, exp_under);
    load(8'hF0);
    start;
    frame(8'hAA, 5, 2, 1'b0, '0, -1);
    cs_n = 1'b1;
    exp_ferr++;
    idle(3);
    check("abort_ferr", n_ferr, exp_ferr);
    check("abort_rx_keep", rx_data, last_rx);
    check("abort_idle_miso", miso, 0);
    start;
    frame(8'h69, W, 2, 1'b0, '0, -1);
    cs_n = 1'b1;
    idle(3);
    load(8'hB4);
    start;
    frame(8'hE1, W, 2, 1'b0, '0, 3);
    cs_n = 1'b1;
    idle(2);
    for (int k = 0; k < 6; k++) begin
      mosi = k[0];
      sclk_rise = 1'b1;
      tick;
      sclk_rise = 1'b0;
      sclk_fall = 1'b1;
      tick;
      sclk_fall = 1'b0;
    end
    idle(2);
    check("cs_high_miso", miso, 0);
    check("cs_high_ferr", n_ferr, exp_ferr);
    start;
    frame(8'hFF, 3, 2, 1'b0, '0, -1);
    load(8'h33);
    rst = 1'b1;
    tick;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_underrun", tx_underrun, 0);
    check("mid_rst_frame_err", frame_err, 0);
    cs_n = 1'b1;
    tick;
    rst = 1'b0;
    full = 1'b0;
    last_rx = '0;
    idle(2);
    check("mid_rst_ferr_cnt", n_ferr, exp_ferr);
    for (int b = 0; b < 12; b++) begin
      if ($urandom_range(1) == 1 && !full) load(W'($urandom));
      start;
      for (int f = 0; f < int'($urandom_range(1, 3)); f++)
        frame(W'($urandom), W, int'($urandom_range(2, 5)), bit'($urandom_range(1)), W'($urandom), -1);
      cs_n = 1'b1;
      idle(2);
    end
    idle(4);
    check("final_under", n_under, exp_under);
    check("final_ferr", n_ferr, exp_ferr);
    check("final_rx_q", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

Mode-0 SPI slave serial/parallel engine that consumes the single-cycle `sclk_rise` / `sclk_fall` strobes produced by the upstream two-channel sequence comparator. It shifts in MOSI on rising SCLK strobes, presents MISO data updated on falling SCLK strobes, and transfers whole frames to and from the parallel side. All SPI pins are already synchronised into `clk` upstream. It sits between the edge-detection stage and the register-file / command decoder.

## Interface
- `WIDTH`, 16: frame length in bits, ≥2; MSB first.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `sclk_rise`  in  1  one-cycle strobe, SCLK rising edge detected.
- `sclk_fall`  in  1  one-cycle strobe, SCLK falling edge detected.
- `cs_n`  in  1  synchronised chip select, active low, same latency as the strobes.
- `mosi`  in  1  synchronised MOSI, aligned with the strobes.
- `miso`  out  1  serial output.
- `tx_data`  in  WIDTH  next frame to transmit.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  WIDTH  last complete received frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `tx_underrun`  out  1  one-cycle pulse: frame started with an empty TX holding register.
- `frame_err`  out  1  one-cycle pulse: `cs_n` deasserted mid-frame.

## Operation
- **States:** IDLE and SHIFT.
- **IDLE → SHIFT** on a cycle with `cs_n`=0. In that cycle:
  - TX shift register loads from the holding register, or all-zeros if the holding register is empty; an empty register also pulses `tx_underrun`.
  - The holding register is emptied.
  - `bit_cnt` is set to 0.
- **SHIFT → IDLE** on any cycle with `cs_n`=1. Strobes in that cycle are ignored. If `bit_cnt`≠0, pulse `frame_err`; the partial RX data is discarded and `rx_data` is not updated.
- **In IDLE**, strobes are ignored and `miso`=0.
- **`sclk_rise` in SHIFT:**
  - `rx_shift` ← {`rx_shift`[WIDTH-2:0], `mosi`}.
  - If `bit_cnt`=WIDTH-1: `rx_data` ← {`rx_shift`[WIDTH-2:0], `mosi`}, pulse `rx_valid`, `bit_cnt` wraps to 0, set `reload_pend`.
  - Otherwise `bit_cnt`+1.
- **`sclk_fall` in SHIFT:**
  - If `reload_pend`: TX shift loads from the holding register (zeros plus `tx_underrun` if empty), the holding register is emptied, and `reload_pend` is cleared. This supports back-to-back frames without `cs_n` toggling.
  - Otherwise TX shift shifts left by one, filling with 0.
- **`miso`** = TX shift MSB while in SHIFT.
- **`sclk_rise` and `sclk_fall` in the same cycle:** both ignored; no state change.
- **TX handshake:**
  - Transfer occurs when `tx_valid`&&`tx_ready`.
  - `tx_ready` = holding register empty.
  - If a transfer and a reload happen in the same cycle, the reload takes the old content and the new word is written; the holding register ends full.
- **`rst` mid-frame:** everything returns to reset values next cycle. No `frame_err` and no `rx_valid` are emitted.

## Timing
- **Reset values:**
  - state=IDLE
  - `miso`=0
  - `tx_ready`=1
  - `rx_data`=0
  - `rx_valid`=0
  - `tx_underrun`=0
  - `frame_err`=0
  - `bit_cnt`=0
  - `reload_pend`=0
  - holding register empty
- **All outputs are registered:**
  - `rx_valid` / `rx_data` change in the cycle after the last `sclk_rise` strobe.
  - `miso` changes in the cycle after the `sclk_fall` strobe, or the cycle after `cs_n` is first seen low.
  - `frame_err` and `tx_underrun` appear the cycle after their cause.
- **`tx_ready`** falls the cycle after an accepted transfer and rises the cycle after the holding register is emptied.
- **Throughput:** the block accepts one strobe per `clk`. Any SCLK slower than `clk`/4 is supported without loss.

## Test plan
- **Single frame:** WIDTH=8, preload `tx_data`=8'hA5, `cs_n` low, MOSI 8'h3C MSB first over 8 rise/fall pairs. Expect `miso` sequence 1,0,1,0,0,1,0,1; `rx_valid` pulse once with `rx_data`=8'h3C.
- **Back-to-back:** two frames without `cs_n` toggling, `tx_data` 8'h81 then 8'h7E loaded during the first frame. Expect `rx_valid` twice; `miso` of frame 2 is 8'h7E, with its MSB valid after the 8th fall of frame 1.
- **Underrun:** `cs_n` low with no word loaded. Expect `tx_underrun` one pulse, `miso`=0 for the whole frame, and RX still completes.
- **Abort:** `cs_n` high after 5 rises. Expect `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, state IDLE; the next full frame receives correctly.
- **Edge cases:** simultaneous rise+fall strobe mid-frame causes no bit change. Strobes while `cs_n`=1 are ignored. `rst` asserted after 3 bits returns all outputs to reset values, with no pulses.
- **Randomized:** random SCLK at `clk`/4 to `clk`/10 with a random `tx_valid` pattern; scoreboard every `rx_data` and `miso` frame.
